// File: rtl/config_chain_loader.sv
// config_chain_loader
// Master end of a serial configuration chain. Parallel words arrive over a
// valid/ready stream and are serialized MSB first into exactly CHAIN_LEN
// enabled shift cycles. A verify pass re-sends the same stream while
// comparing every bit that leaves the far end of the chain, so the chain
// contents are confirmed and left unchanged.
module config_chain_loader #(
    parameter int CHAIN_LEN = 100,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       mismatch_count,
    output logic              configuration_input,
    output logic              configuration_enable,
    input  logic              configuration_output
);

    // Words per pass and the number of used bits in the final word.
    localparam int NW = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int R  = CHAIN_LEN - (NW - 1) * WORD_W;

    // Counter widths: bits left in the holding register, words accepted.
    localparam int BW = $clog2(WORD_W + 1);
    localparam int AW = $clog2(NW + 1);

    localparam logic [AW-1:0] NW_L    = AW'(NW);
    localparam logic [AW-1:0] LAST_IX = AW'(NW - 1);
    localparam logic [BW-1:0] FULL_M1 = BW'(WORD_W - 1);
    localparam logic [BW-1:0] LAST_M1 = BW'(R - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] hold;         // remaining bits, next one at the MSB
    logic [BW-1:0]     hold_cnt;     // bits still waiting behind configuration_input
    logic [AW-1:0]     words_acc;    // words accepted in this pass
    logic              verify_mode;  // latched with start
    logic              accept;
    logic              last_word;
    logic              far_mismatch;

    // The holding register may take a new word when it is empty, or when
    // the bit now on configuration_input is its last one, so back-to-back
    // words shift with no bubble.
    assign s_ready      = (state == SHIFT) && (words_acc < NW_L) && (hold_cnt == '0);
    assign accept       = s_valid && s_ready;
    assign last_word    = (words_acc == LAST_IX);
    assign far_mismatch = configuration_output != configuration_input;

    // Pass sequencing, serialization and far-end comparison.
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state                <= IDLE;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            error                <= 1'b0;
            mismatch_count       <= 16'd0;
            configuration_input  <= 1'b0;
            configuration_enable <= 1'b0;
            hold                 <= '0;
            hold_cnt             <= '0;
            words_acc            <= '0;
            verify_mode          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state                <= SHIFT;
                        busy                 <= 1'b1;
                        verify_mode          <= verify;
                        error                <= 1'b0;
                        mismatch_count       <= 16'd0;
                        words_acc            <= '0;
                        hold_cnt             <= '0;
                        configuration_enable <= 1'b0;
                    end
                end

                SHIFT: begin
                    // The chain's far-end bit is compared before this edge
                    // shifts it out; the bit going in is what should return.
                    if (configuration_enable && verify_mode && far_mismatch) begin
                        error <= 1'b1;
                        if (mismatch_count != 16'hFFFF) begin
                            mismatch_count <= mismatch_count + 16'd1;
                        end
                    end

                    if (accept) begin
                        // New word: its MSB goes straight onto the chain
                        // input, the rest waits in the holding register.
                        configuration_input  <= s_data[WORD_W-1];
                        configuration_enable <= 1'b1;
                        hold                 <= s_data << 1;
                        hold_cnt             <= last_word ? LAST_M1 : FULL_M1;
                        words_acc            <= words_acc + 1'b1;
                    end else if (configuration_enable && (hold_cnt != '0)) begin
                        configuration_input <= hold[WORD_W-1];
                        hold                <= hold << 1;
                        hold_cnt            <= hold_cnt - 1'b1;
                    end else if (configuration_enable) begin
                        // Holding register just drained: either the pass is
                        // complete or the chain waits for the next word.
                        configuration_enable <= 1'b0;
                        if (words_acc == NW_L) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: two instances (100-bit chain and 20-bit
// chain, 32-bit words) driving behavioural shift-register chains, a
// stream-level reference model compared every cycle, and literal checks.
module tb_config_chain_loader;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rstn    = 2'b00;
    logic [1:0]        start   = 2'b00;
    logic [1:0]        verify  = 2'b00;
    logic [1:0]        s_valid = 2'b00;
    logic [1:0][W-1:0] s_data  = '0;
    logic [1:0]        s_ready, busy, done, error, cin, cen, cout;
    logic [1:0][15:0]  mcount;

    // Behavioural chains: bit 0 receives the new bit, far end is bit CL-1.
    logic [1:0][99:0] chain = '0;
    assign cout[0] = chain[0][99];
    assign cout[1] = chain[1][19];

    config_chain_loader #(.CHAIN_LEN(100), .WORD_W(W)) dut0 (
        .clk(clk), .RSTN(rstn[0]), .start(start[0]), .verify(verify[0]),
        .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .busy(busy[0]), .done(done[0]), .error(error[0]),
        .mismatch_count(mcount[0]), .configuration_input(cin[0]),
        .configuration_enable(cen[0]), .configuration_output(cout[0])
    );

    config_chain_loader #(.CHAIN_LEN(20), .WORD_W(W)) dut1 (
        .clk(clk), .RSTN(rstn[1]), .start(start[1]), .verify(verify[1]),
        .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .busy(busy[1]), .done(done[1]), .error(error[1]),
        .mismatch_count(mcount[1]), .configuration_input(cin[1]),
        .configuration_enable(cen[1]), .configuration_output(cout[1])
    );

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (cen[k]) chain[k] <= {chain[k][98:0], cin[k]};
    end

    int cl[2]  = '{100, 20};
    int nwa[2] = '{4, 1};
    int ra[2]  = '{4, 20};

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // ---------------- reference model (stream level) ----------------
    int  m_phase[2];  // 0 idle, 1 shifting, 2 done pulse
    int  m_acc[2], m_pend[2], m_shift[2], m_mc[2], m_wr[2], m_rd[2];
    bit  m_vfy[2], m_err[2], m_seen[2];
    bit  ebits[2][100];

    always @(posedge clk) begin
        bit en_now, rdy_now, b;
        int nb;
        for (int k = 0; k < 2; k++) begin
            en_now  = (m_phase[k] == 1) && (m_pend[k] > 0);
            rdy_now = (m_phase[k] == 1) && (m_acc[k] < nwa[k]) && (m_pend[k] <= 1);
            if (!rstn[k]) begin
                m_seen[k] = 1; m_phase[k] = 0; m_acc[k] = 0; m_pend[k] = 0;
                m_shift[k] = 0; m_err[k] = 0; m_mc[k] = 0; m_vfy[k] = 0;
                m_wr[k] = 0; m_rd[k] = 0;
            end else if (m_phase[k] == 0) begin
                if (start[k]) begin
                    m_phase[k] = 1; m_vfy[k] = verify[k]; m_err[k] = 0; m_mc[k] = 0;
                    m_acc[k] = 0; m_pend[k] = 0; m_shift[k] = 0; m_wr[k] = 0; m_rd[k] = 0;
                end
            end else if (m_phase[k] == 1) begin
                if (en_now) begin
                    b = ebits[k][m_rd[k]];
                    m_rd[k]++;
                    if (m_vfy[k] && (chain[k][cl[k]-1] != b)) begin
                        m_err[k] = 1;
                        if (m_mc[k] < 65535) m_mc[k]++;
                    end
                    m_pend[k]--;
                    m_shift[k]++;
                end
                if (rdy_now && s_valid[k]) begin
                    nb = (m_acc[k] == nwa[k] - 1) ? ra[k] : W;
                    for (int i = 0; i < nb; i++) begin
                        ebits[k][m_wr[k]] = s_data[k][W-1-i];
                        m_wr[k]++;
                    end
                    m_pend[k] += nb;
                    m_acc[k]++;
                end
                if (m_shift[k] == cl[k]) m_phase[k] = 2;
            end else begin
                m_phase[k] = 0;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        bit e_en, e_rdy;
        for (int k = 0; k < 2; k++) begin
            if (m_seen[k]) begin
                e_en  = (m_phase[k] == 1) && (m_pend[k] > 0);
                e_rdy = (m_phase[k] == 1) && (m_acc[k] < nwa[k]) && (m_pend[k] <= 1);
                check("busy", k, busy[k], m_phase[k] == 1);
                check("done", k, done[k], m_phase[k] == 2);
                check("s_ready", k, s_ready[k], e_rdy);
                check("configuration_enable", k, cen[k], e_en);
                check("error", k, error[k], m_err[k]);
                check("mismatch_count", k, mcount[k], m_mc[k]);
                if (e_en) check("configuration_input", k, cin[k], ebits[k][m_rd[k]]);
            end
        end
    end

    // Pass statistics for literal checks.
    int en_count[2], run_len[2], max_run[2], done_seen[2];
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cen[k]) begin
                en_count[k]++;
                run_len[k]++;
                if (run_len[k] > max_run[k]) max_run[k] = run_len[k];
            end else begin
                run_len[k] = 0;
            end
            if (done[k]) done_seen[k]++;
        end
    end

    task automatic clear_stats(input int k);
        en_count[k] = 0; run_len[k] = 0; max_run[k] = 0; done_seen[k] = 0;
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] wbuf[2][4];
    logic [W-1:0] cont_words[2][4];
    logic [127:0] cur_content[2];

    // Stream the pass would put in the chain, first bit at position CL-1.
    function automatic logic [127:0] build(input int k);
        logic [127:0] s;
        int nb;
        s = '0;
        for (int w = 0; w < nwa[k]; w++) begin
            nb = (w == nwa[k] - 1) ? ra[k] : W;
            for (int i = 0; i < nb; i++) s = {s[126:0], wbuf[k][w][W-1-i]};
        end
        return s;
    endfunction

    function automatic logic [127:0] chain_bits(input int k);
        logic [127:0] c;
        c = 128'(chain[k]);
        return c & ((128'd1 << cl[k]) - 128'd1);
    endfunction

    task automatic record_pass(input int k);
        cur_content[k] = build(k);
        for (int i = 0; i < 4; i++) cont_words[k][i] = wbuf[k][i];
    endtask

    task automatic run_pass(input int k, input bit vfy, input int vprob, input int stall_len, input int abort_at);
        int idx, stalls, shifts, cyc;
        bit acc, got, v;
        @(posedge clk); #1;
        start[k] = 1'b1; verify[k] = vfy;
        @(posedge clk); #1;
        start[k] = 1'b0; verify[k] = 1'b0;
        idx = 0; stalls = 0; shifts = 0; cyc = 0;
        while (idx < nwa[k] && cyc < 1000) begin
            v = ($urandom_range(99) < vprob);
            if (idx == 1 && stalls < stall_len) v = 1'b0;
            s_valid[k] = v;
            s_data[k]  = wbuf[k][idx];
            @(negedge clk);
            acc = s_valid[k] && s_ready[k];
            if (idx == 1 && !v && s_ready[k]) stalls++;
            if (cen[k]) shifts++;
            if (abort_at > 0 && shifts == abort_at) begin
                #1 rstn[k] = 1'b0;
                @(posedge clk); #1;
                rstn[k] = 1'b1; s_valid[k] = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        s_valid[k] = 1'b0;
        s_data[k]  = $urandom;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (done[k]) got = 1'b1;
        end
        check("done_within_budget", k, got, 1'b1);
        @(posedge clk); #1;
    endtask

    localparam logic [99:0] STREAM1 = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 4'hF};

    initial begin
        int k, exp_mc;
        bit vfy;
        for (int i = 0; i < 4; i++) begin
            wbuf[0][i] = '0; wbuf[1][i] = '0;
            cont_words[0][i] = '0; cont_words[1][i] = '0;
        end
        cur_content[0] = '0; cur_content[1] = '0;

        // Reset
        repeat (3) @(posedge clk);
        #1 rstn = 2'b11;
        @(negedge clk);
        check("reset_cfg_in", 0, cin[0], 1'b0);
        check("reset_cfg_en", 0, cen[0], 1'b0);
        check("reset_mismatch_count", 1, mcount[1], 16'd0);

        // 1: load of four words, valid always high
        wbuf[0][0] = 32'hDEADBEEF; wbuf[0][1] = 32'h01234567;
        wbuf[0][2] = 32'h89ABCDEF; wbuf[0][3] = 32'hF0000000;
        check("model_stream_literal", 0, build(0), 128'(STREAM1));
        clear_stats(0);
        run_pass(0, 1'b0, 100, 0, 0);
        check("t1_enable_count", 0, en_count[0], 100);
        check("t1_enable_run", 0, max_run[0], 100);
        check("t1_done_pulses", 0, done_seen[0], 1);
        check("t1_chain", 0, chain_bits(0), 128'(STREAM1));
        record_pass(0);

        // 2: verify with identical words
        run_pass(0, 1'b1, 100, 0, 0);
        check("t2_mismatch_count", 0, mcount[0], 16'd0);
        check("t2_error", 0, error[0], 1'b0);
        check("t2_chain_unchanged", 0, chain_bits(0), 128'(STREAM1));
        check("t2_deep_word", 0, chain[0][99:68], 32'hDEADBEEF);
        record_pass(0);

        // 3: verify with one flipped bit, error sticky until next start
        wbuf[0][1] = 32'h01234566;
        run_pass(0, 1'b1, 100, 0, 0);
        check("t3_mismatch_count", 0, mcount[0], 16'd1);
        check("t3_error", 0, error[0], 1'b1);
        repeat (5) @(posedge clk);
        #1 check("t3_error_sticky", 0, error[0], 1'b1);
        record_pass(0);
        wbuf[0][1] = 32'h01234567;
        run_pass(0, 1'b0, 100, 0, 0);
        check("t3_error_cleared", 0, error[0], 1'b0);
        record_pass(0);

        // 4: valid stalls after word 1
        clear_stats(0);
        run_pass(0, 1'b0, 100, 5, 0);
        check("t4_enable_count", 0, en_count[0], 100);
        check("t4_chain", 0, chain_bits(0), 128'(STREAM1));
        record_pass(0);

        // 5: reset at the 50th shift cycle, then a full pass
        clear_stats(0);
        run_pass(0, 1'b0, 100, 0, 50);
        @(negedge clk);
        check("t5_enable_after_reset", 0, cen[0], 1'b0);
        check("t5_busy_after_reset", 0, busy[0], 1'b0);
        repeat (20) @(posedge clk);
        #1 check("t5_no_done", 0, done_seen[0], 0);
        check("t5_partial_shifts", 0, en_count[0], 50);
        clear_stats(0);
        run_pass(0, 1'b0, 100, 0, 0);
        check("t5_full_enable_count", 0, en_count[0], 100);
        check("t5_chain", 0, chain_bits(0), 128'(STREAM1));
        record_pass(0);

        // 6: short chain, one word, start pulsed while busy
        wbuf[1][0] = 32'hABCDE123;
        clear_stats(1);
        fork
            run_pass(1, 1'b0, 100, 0, 0);
            begin
                repeat (8) @(posedge clk);
                #1 start[1] = 1'b1;
                @(posedge clk);
                #1 start[1] = 1'b0;
            end
        join
        check("t6_enable_count", 1, en_count[1], 20);
        check("t6_chain", 1, chain_bits(1), 128'h0ABCDE);
        check("t6_done_pulses", 1, done_seen[1], 1);
        record_pass(1);

        // Randomized passes
        for (int it = 0; it < 14; it++) begin
            k   = int'($urandom_range(1));
            vfy = 1'($urandom_range(1));
            if (vfy) begin
                for (int i = 0; i < 4; i++) wbuf[k][i] = cont_words[k][i];
                if ($urandom_range(1) == 1)
                    wbuf[k][$urandom_range(nwa[k] - 1)] ^= (32'd1 << $urandom_range(31));
                exp_mc = $countones(build(k) ^ cur_content[k]);
            end else begin
                for (int i = 0; i < 4; i++) wbuf[k][i] = $urandom;
                exp_mc = 0;
            end
            run_pass(k, vfy, int'($urandom_range(40, 100)), 0, 0);
            check("rand_mismatch_count", k, mcount[k], 128'(exp_mc));
            check("rand_error", k, error[k], exp_mc != 0);
            check("rand_chain", k, chain_bits(k), build(k));
            record_pass(k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
